// File: rtl/icache_bank_arbiter.sv
// Even/odd I-cache data-bank arbiter between fetch reads and refill line writes,
// with a one-cycle aligned copy of the fetch block-select fields. Optional macro: FETCH_SINGLE_BANK_EN.
module icache_bank_arbiter #(
    parameter int SIZE_PC      = 32,
    parameter int INDEX_W      = 7,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fetchReq_i,
    input  logic [SIZE_PC-1:0] fetchPC_i,
    output logic               fetchGrant_o,
    input  logic               fillReq_i,
    input  logic               fillBank_i,
    input  logic [INDEX_W-1:0] fillIndex_i,
    output logic               fillGrant_o,
    output logic               evenEn_o,
    output logic               oddEn_o,
    output logic               evenWe_o,
    output logic               oddWe_o,
    output logic [INDEX_W-1:0] evenIndex_o,
    output logic [INDEX_W-1:0] oddIndex_o,
    output logic               rdValid_o,
    output logic               startBlock_o,
    output logic [1:0]         firstInst_o
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic               sb;
    logic [INDEX_W-1:0] lineIdx;
    logic [INDEX_W-1:0] lineIdxInc;
    logic               singleBank;
    logic [1:0]         fetchUse;
    logic [INDEX_W-1:0] fetchIdx [2];
    logic               conflict;
    logic               forceFill;
    logic [3:0]         starveQ;
    logic [1:0]         bankEn;
    logic [1:0]         bankWe;
    logic [INDEX_W-1:0] bankIndex [2];
    logic               unusedPc;

    assign sb         = fetchPC_i[4];
    assign lineIdx    = fetchPC_i[INDEX_W+4:5];
    assign lineIdxInc = lineIdx + INDEX_W'(1);
    assign unusedPc   = ^{fetchPC_i[SIZE_PC-1:INDEX_W+5], fetchPC_i[1:0]};

`ifdef FETCH_SINGLE_BANK_EN
    // A bundle starting at slot 0 never spills into the next block.
    assign singleBank = (fetchPC_i[3:2] == 2'b00);
`else
    assign singleBank = 1'b0;
`endif

    assign fetchUse[0] = !singleBank || !sb;
    assign fetchUse[1] = !singleBank || sb;
    // When the fetch starts in the odd block the even half comes from the next line.
    assign fetchIdx[0] = sb ? lineIdxInc : lineIdx;
    assign fetchIdx[1] = lineIdx;

    assign conflict  = fetchUse[fillBank_i];
    assign forceFill = (starveQ == LIMIT);

    assign fetchGrant_o = reset && fetchReq_i && !(fillReq_i && conflict && forceFill);
    assign fillGrant_o  = reset && fillReq_i && (!fetchReq_i || !conflict || forceFill);

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bank
            localparam logic BANK_ID = (gi == 1);
            logic fillHere;
            logic fetchHere;
            assign fillHere      = fillGrant_o && (fillBank_i == BANK_ID);
            assign fetchHere     = fetchGrant_o && fetchUse[gi];
            assign bankEn[gi]    = fillHere || fetchHere;
            assign bankWe[gi]    = fillHere;
            assign bankIndex[gi] = fillHere  ? fillIndex_i :
                                   fetchHere ? fetchIdx[gi] : '0;
        end
    endgenerate

    assign evenEn_o    = bankEn[0];
    assign oddEn_o     = bankEn[1];
    assign evenWe_o    = bankWe[0];
    assign oddWe_o     = bankWe[1];
    assign evenIndex_o = bankIndex[0];
    assign oddIndex_o  = bankIndex[1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starveQ <= '0;
        end else if (!fillReq_i || fillGrant_o) begin
            starveQ <= '0;
        end else if (starveQ != LIMIT) begin
            starveQ <= starveQ + 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdValid_o    <= 1'b0;
            startBlock_o <= 1'b0;
            firstInst_o  <= 2'b00;
        end else begin
            rdValid_o <= fetchGrant_o;
            if (fetchGrant_o) begin
                startBlock_o <= sb;
                firstInst_o  <= fetchPC_i[3:2];
            end
        end
    end

endmodule

// File: tb/tb_icache_bank_arbiter.sv
// Directed self-checking bench for icache_bank_arbiter (default parameters).
module tb_icache_bank_arbiter;

    logic        clk;
    logic        reset;
    logic        fetchReq;
    logic [31:0] fetchPC;
    logic        fetchGrant;
    logic        fillReq;
    logic        fillBank;
    logic [6:0]  fillIndex;
    logic        fillGrant;
    logic        evenEn, oddEn, evenWe, oddWe;
    logic [6:0]  evenIndex, oddIndex;
    logic        rdValid, startBlock;
    logic [1:0]  firstInst;

    int checkCount = 0;
    int passCount  = 0;

    icache_bank_arbiter #(.SIZE_PC(32), .INDEX_W(7), .STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset),
        .fetchReq_i(fetchReq), .fetchPC_i(fetchPC), .fetchGrant_o(fetchGrant),
        .fillReq_i(fillReq), .fillBank_i(fillBank), .fillIndex_i(fillIndex),
        .fillGrant_o(fillGrant),
        .evenEn_o(evenEn), .oddEn_o(oddEn), .evenWe_o(evenWe), .oddWe_o(oddWe),
        .evenIndex_o(evenIndex), .oddIndex_o(oddIndex),
        .rdValid_o(rdValid), .startBlock_o(startBlock), .firstInst_o(firstInst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checkCount++;
        if (got === exp) passCount++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic checkBanks(input string tag, input logic fG, input logic lG,
                              input logic eEn, input logic eWe, input logic [6:0] eIdx,
                              input logic oEn, input logic oWe, input logic [6:0] oIdx);
        checkVal({tag, ".fetchGrant"}, 32'(fetchGrant), 32'(fG));
        checkVal({tag, ".fillGrant"},  32'(fillGrant),  32'(lG));
        checkVal({tag, ".evenEn"},     32'(evenEn),     32'(eEn));
        checkVal({tag, ".evenWe"},     32'(evenWe),     32'(eWe));
        checkVal({tag, ".evenIndex"},  32'(evenIndex),  32'(eIdx));
        checkVal({tag, ".oddEn"},      32'(oddEn),      32'(oEn));
        checkVal({tag, ".oddWe"},      32'(oddWe),      32'(oWe));
        checkVal({tag, ".oddIndex"},   32'(oddIndex),   32'(oIdx));
    endtask

    task automatic checkRead(input string tag, input logic v, input logic s, input logic [1:0] f);
        checkVal({tag, ".rdValid"},    32'(rdValid),    32'(v));
        checkVal({tag, ".startBlock"}, 32'(startBlock), 32'(s));
        checkVal({tag, ".firstInst"},  32'(firstInst),  32'(f));
    endtask

    initial begin
        reset = 1'b0; fetchReq = 1'b1; fetchPC = 32'h48;
        fillReq = 1'b1; fillBank = 1'b1; fillIndex = 7'd5;
        repeat (2) @(negedge clk);
        checkBanks("inReset", 0, 0, 0, 0, 7'd0, 0, 0, 7'd0);
        checkRead("inReset", 0, 0, 2'd0);

        fillReq = 1'b0;
        reset = 1'b1;
        #1;
        $display("fetch PC=0x48");
        checkBanks("fetch48", 1, 0, 1, 0, 7'd2, 1, 0, 7'd2);
        @(negedge clk);
        checkRead("fetch48", 1, 0, 2'd2);

        fetchPC = 32'hFF4;
        #1;
        $display("fetch PC=0xFF4 wrap");
        checkBanks("fetchFF4", 1, 0, 1, 0, 7'd0, 1, 0, 7'd127);
        @(negedge clk);
        checkRead("fetchFF4", 1, 1, 2'd1);

        // Both held: fetch wins four cycles, then the starved fill is forced through.
        fetchPC = 32'h48; fillReq = 1'b1; fillBank = 1'b1; fillIndex = 7'd5;
        for (int c = 0; c < 8; c++) begin
            if (c >= 6) fetchPC = 32'hFF4;
            #1;
            $display("contend cycle %0d", c);
            if (c == 4) checkBanks("forceFill", 0, 1, 0, 0, 7'd0, 1, 1, 7'd5);
            else begin
                checkVal("contend.fetchGrant", 32'(fetchGrant), 32'd1);
                checkVal("contend.fillGrant",  32'(fillGrant),  32'd0);
                checkVal("contend.oddWe",      32'(oddWe),      32'd0);
            end
            if (c == 5) checkVal("afterForce.rdValid", 32'(rdValid), 32'd0);
            @(negedge clk);
        end
        checkVal("preReset.starve", 32'(dut.starveQ), 32'd3);
        checkRead("preReset", 1, 1, 2'd1);

        #2 reset = 1'b0;
        #1;
        $display("async reset mid-stream");
        checkVal("midReset.starve", 32'(dut.starveQ), 32'd0);
        checkRead("midReset", 0, 0, 2'd0);
        checkBanks("midReset", 0, 0, 0, 0, 7'd0, 0, 0, 7'd0);
        @(negedge clk);
        checkRead("heldReset", 0, 0, 2'd0);
        checkBanks("heldReset", 0, 0, 0, 0, 7'd0, 0, 0, 7'd0);

        reset = 1'b1; fetchPC = 32'h48;
        for (int c = 0; c < 5; c++) begin
            #1;
            $display("post-reset contend cycle %0d", c);
            checkVal("restart.fetchGrant", 32'(fetchGrant), 32'(c != 4));
            checkVal("restart.fillGrant",  32'(fillGrant),  32'(c == 4));
            @(negedge clk);
        end

        fillReq = 1'b0;
        #1;
        $display("fetch before fill-only");
        checkVal("refetch.fetchGrant", 32'(fetchGrant), 32'd1);
        @(negedge clk);

        fetchReq = 1'b0; fillReq = 1'b1; fillBank = 1'b0; fillIndex = 7'd9;
        #1;
        $display("fill only bank0 idx9");
        checkBanks("fillOnly", 0, 1, 1, 1, 7'd9, 0, 0, 7'd0);
        @(negedge clk);
        checkVal("fillOnly.rdValid", 32'(rdValid), 32'd0);

        fetchReq = 1'b1; fillReq = 1'b0; fetchPC = 32'h48;
        @(negedge clk);
        fetchReq = 1'b0;
        #1;
        $display("both idle");
        checkBanks("idle", 0, 0, 0, 0, 7'd0, 0, 0, 7'd0);
        checkVal("idle.rdValidPrev", 32'(rdValid), 32'd1);
        @(negedge clk);
        checkVal("idle.rdValid", 32'(rdValid), 32'd0);

        fetchReq = 1'b1; fetchPC = 32'h40; fillReq = 1'b1; fillBank = 1'b1; fillIndex = 7'd3;
        #1;
        $display("fetch PC=0x40 with fill bank1 idx3");
`ifdef FETCH_SINGLE_BANK_EN
        checkBanks("single", 1, 1, 1, 0, 7'd2, 1, 1, 7'd3);
`else
        checkBanks("single", 1, 0, 1, 0, 7'd2, 1, 0, 7'd2);
`endif
        @(negedge clk);
        checkRead("single", 1, 0, 2'd0);

        fillReq = 1'b0;
        #1;
        $display("fetch PC=0x40 alone");
`ifdef FETCH_SINGLE_BANK_EN
        checkBanks("single40", 1, 0, 1, 0, 7'd2, 0, 0, 7'd0);
`else
        checkBanks("single40", 1, 0, 1, 0, 7'd2, 1, 0, 7'd2);
`endif
        @(negedge clk);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
